serial_byte_rx: RTL and testbench
=================================

Name: serial_byte_rx

Overview:
Bit-serial receiver that reassembles a framed serial bit stream into a parallel WIDTH-bit word. It is the receiving end of the serial link whose transmitter shifts parallel data out one bit per cycle. A parameter selects LSB-first or MSB-first bit order, so the same block either reproduces the transmitted word or delivers its bit-reversed image. The completed word is presented on a valid/ready output handshake to downstream logic.

Parameters:
WIDTH, 8, number of data bits per frame (2..32)
LSB_FIRST, 1, 1: k-th received bit -> out_data[k]; 0: k-th received bit -> out_data[WIDTH-1-k]

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  synchronous, active-high reset
sin_valid  input  1  sin_data/sin_start qualify this cycle
sin_data  input  1  serial data bit
sin_start  input  1  with sin_valid: this bit is bit 0 of a new frame
out_data  output  WIDTH  assembled word; stable while out_valid=1
out_valid  output  1  word available
out_ready  input  1  consumer accepts word when out_valid && out_ready
overrun  output  1  1-cycle pulse: a frame start was dropped because the output was still held
frame_err  output  1  1-cycle pulse: a frame was restarted before completion
parity_err  output  1  parity result for the current word (see Optional Feature)

Behaviour:
- Reset (rst=1 at posedge): state IDLE, bit counter 0, shift register 0. out_data=0, out_valid=0, overrun=0, frame_err=0, parity_err=0. A partial frame or held word is discarded. rst overrides every other input.
- States: IDLE, SHIFT, HOLD. All outputs are registered.
- IDLE: sin_valid && sin_start -> store the bit as bit 0, counter=1, go to SHIFT. sin_valid without sin_start is ignored.
- SHIFT: sin_valid=0 stalls the frame; counter and register hold. sin_valid && !sin_start stores the bit at index counter and increments counter.
- SHIFT, frame complete: when the last data bit is stored (counter reaches WIDTH), go to HOLD. out_data and out_valid=1 update at that same posedge. Latency is 1 cycle from the last bit sample to out_valid.
- SHIFT restart: sin_valid && sin_start mid-frame discards the partial word, stores the bit as bit 0, sets counter=1, stays in SHIFT, and pulses frame_err for 1 cycle. With WIDTH=1 semantics excluded, a start can never coincide with completion.
- HOLD: out_valid=1, and out_data is frozen. out_ready=1 -> out_valid=0 on the next edge.
- HOLD, out_ready=1 and sin_valid && sin_start in the same cycle: the word is accepted and the new bit becomes bit 0 of a new frame (go to SHIFT, counter=1). Back-to-back frames need no idle cycle.
- HOLD, sin_valid && sin_start while out_ready=0: the bit is dropped, overrun pulses 1 cycle, and the held word is unchanged. Non-start bits in HOLD are ignored silently.
- HOLD, out_ready=1 with no start: go to IDLE.
- Bit placement: per LSB_FIRST. The index is never out of range. The counter is $clog2(WIDTH+1) bits wide and saturates at WIDTH.
- out_valid must never drop without out_ready, except on reset.

Optional Feature:
Macro RX_PARITY_CHECK_EN.
- Defined: each frame carries WIDTH data bits followed by one even-parity bit. The frame completes on the parity bit, so latency is 1 cycle after the parity bit. parity_err = XOR of all data bits and the parity bit, registered together with out_valid and held with the word. A start during the parity bit position is treated as a restart (frame_err).
- Not defined: frames are exactly WIDTH bits, no parity bit is consumed, and parity_err is constant 0.

Test Plan:
- LSB_FIRST=1, stream 1,0,1,1,0,0,1,0 (start on first bit), out_ready=1 -> out_data=0x4D, out_valid high for exactly 1 cycle, 1 cycle after the 8th bit.
- LSB_FIRST=0, same stream -> out_data=0xB2 (bit-reverse of 0x4D).
- LSB_FIRST=1, stream 0xA5 with sin_valid=0 for 3 cycles after bit 3 -> out_data=0xA5; completion is delayed exactly 3 cycles.
- Frame 0x3C received, out_ready=0; start bit arrives -> overrun pulses once, out_data stays 0x3C. Then out_ready=1 while the next frame 0xC3 starts the same cycle -> 0x3C accepted, next out_data=0xC3.
- 4 bits sent, then a new start, then 0x81 -> frame_err pulses once, out_data=0x81. rst asserted mid-frame -> all outputs 0, and the next full frame decodes correctly.
- RX_PARITY_CHECK_EN: 0x4D plus parity bit 0 -> parity_err=0. Same data plus parity bit 1 -> parity_err=1, out_data=0x4D.

Source files
------------

// File: rtl/serial_byte_rx.sv
// Bit-serial frame receiver: assembles WIDTH bits into a word on a valid/ready output.
// Optional even-parity bit per frame when RX_PARITY_CHECK_EN is defined.
module serial_byte_rx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin_data,
    input  logic             sin_start,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             r_frame_err;

    logic             w_start;
    logic             w_bit;
    logic             w_last;
    logic [CW-1:0]    w_pos;
    logic [IW-1:0]    w_idx;
    logic [IW-1:0]    w_idx0;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_ins;

    // Bit position is clamped so the parity slot never indexes past the word.
    always_comb begin
        w_start = sin_valid & sin_start;
        w_bit   = sin_valid & ~sin_start;
        w_pos   = (r_cnt < CW'(WIDTH)) ? r_cnt : '0;
        w_idx   = LSB_FIRST ? IW'(w_pos)
                            : IW'(CW'(WIDTH - 1) - w_pos);
        w_idx0  = LSB_FIRST ? '0 : IW'(WIDTH - 1);
        w_first = '0;
        w_first[w_idx0] = sin_data;
        w_ins   = r_shift;
        w_ins[w_idx] = sin_data;
`ifdef RX_PARITY_CHECK_EN
        w_last  = (r_cnt == CW'(WIDTH));
`else
        w_last  = (r_cnt == CW'(WIDTH - 1));
`endif
    end

`ifdef RX_PARITY_CHECK_EN
    logic r_parity_err;
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef RX_PARITY_CHECK_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_shift <= w_first;
                        r_cnt   <= CW'(1);
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_start) begin
                        r_shift     <= w_first;
                        r_cnt       <= CW'(1);
                        r_frame_err <= 1'b1;
                    end else if (w_bit) begin
                        if (w_last) begin
`ifdef RX_PARITY_CHECK_EN
                            r_data       <= r_shift;
                            r_parity_err <= ^{r_shift, sin_data};
`else
                            r_data  <= w_ins;
                            r_shift <= w_ins;
`endif
                            r_valid <= 1'b1;
                            r_cnt   <= CW'(WIDTH);
                            r_state <= HOLD;
                        end else begin
                            r_shift <= w_ins;
                            r_cnt   <= r_cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (w_start) begin
                            r_shift <= w_first;
                            r_cnt   <= CW'(1);
                            r_state <= SHIFT;
                        end else begin
                            r_cnt   <= '0;
                            r_state <= IDLE;
                        end
                    end else if (w_start) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out_data  = r_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Randomized + directed bench for serial_byte_rx, one LSB-first and one
// MSB-first instance fed the same stream, checked against a frame-level model.
module tb_serial_byte_rx;

    localparam int W = 8;
`ifdef RX_PARITY_CHECK_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         v;
    logic         d;
    logic         s;
    logic         rdy;
    logic [W-1:0] dl;
    logic [W-1:0] dm;
    logic         vl;
    logic         vm;
    logic         ol;
    logic         om;
    logic         fl;
    logic         fm;
    logic         pl;
    logic         pm;

    serial_byte_rx #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst),
        .sin_valid(v), .sin_data(d), .sin_start(s),
        .out_data(dl), .out_valid(vl), .out_ready(rdy),
        .overrun(ol), .frame_err(fl), .parity_err(pl)
    );

    serial_byte_rx #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst),
        .sin_valid(v), .sin_data(d), .sin_start(s),
        .out_data(dm), .out_valid(vm), .out_ready(rdy),
        .overrun(om), .frame_err(fm), .parity_err(pm)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Frame-level reference: collected bits of the frame in progress,
    // plus the word currently offered downstream.
    bit           q[$];
    bit           m_valid;
    bit           m_ovr;
    bit           m_ferr;
    bit           m_perr;
    logic [W-1:0] m_lsb;
    logic [W-1:0] m_msb;

    task automatic model_step();
        m_ovr  = 0;
        m_ferr = 0;
        if (rst) begin
            q.delete();
            m_valid = 0;
            m_perr  = 0;
            m_lsb   = '0;
            m_msb   = '0;
        end else if (m_valid) begin
            if (rdy) m_valid = 0;
            if (v && s) begin
                if (rdy) q = '{d};
                else m_ovr = 1;
            end
        end else if (v && s) begin
            if (q.size() > 0) m_ferr = 1;
            q = '{d};
        end else if (v && q.size() > 0) begin
            q.push_back(d);
            if (q.size() == FLEN) begin
                m_perr = 0;
                for (int k = 0; k < W; k++) begin
                    m_lsb[k]     = q[k];
                    m_msb[W-1-k] = q[k];
                end
`ifdef RX_PARITY_CHECK_EN
                for (int k = 0; k < FLEN; k++)
                    m_perr = m_perr ^ q[k];
`endif
                m_valid = 1;
                q.delete();
            end
        end
    endtask

    task automatic step(input logic rv, input logic rd,
                        input logic rs, input logic rr,
                        input logic rrst = 1'b0);
        v   = rv;
        d   = rd;
        s   = rs;
        rdy = rr;
        rst = rrst;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("valid_lsb", vl, m_valid);
        check("valid_msb", vm, m_valid);
        check("data_lsb", dl, m_lsb);
        check("data_msb", dm, m_msb);
        check("overrun", ol, m_ovr);
        check("frame_err", fl, m_ferr);
        check("frame_err_msb", fm, m_ferr);
        check("parity", pl, m_perr);
    endtask

    task automatic send_word(input logic [W-1:0] w,
                             input logic rr,
                             input logic flip = 1'b0,
                             input int st_at = -1,
                             input int st_n = 0);
        for (int k = 0; k < W; k++) begin
            step(1'b1, w[k], k == 0, rr);
            if (k == st_at)
                for (int j = 0; j < st_n; j++) step(1'b0, 1'b0, 1'b0, rr);
        end
`ifdef RX_PARITY_CHECK_EN
        step(1'b1, (^w) ^ flip, 1'b0, rr);
`else
        if (flip) step(1'b0, 1'b0, 1'b0, rr);
`endif
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_valid", vl, 1'b0);
        check("rst_data", dl, 8'h00);

        send_word(8'h4D, 1'b1);
        check("4D_valid", vl, 1'b1);
        check("4D_lsb", dl, 8'h4D);
        check("B2_msb", dm, 8'hB2);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("4D_one_cycle", vl, 1'b0);

        send_word(8'hA5, 1'b1, 1'b0, 3, 3);
        check("A5_lsb", dl, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        send_word(8'h3C, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("ovr_pulse", ol, 1'b1);
        check("ovr_held", dl, 8'h3C);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("ovr_once", ol, 1'b0);
        send_word(8'hC3, 1'b1);
        check("C3_lsb", dl, 8'hC3);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 4; k++) step(1'b1, k[0], k == 0, 1'b1);
        send_word(8'h81, 1'b1);
        check("81_lsb", dl, 8'h81);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        for (int k = 0; k < 3; k++) step(1'b1, 1'b1, k == 0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_mid_data", dl, 8'h00);
        check("rst_mid_valid", vl, 1'b0);
        send_word(8'h5A, 1'b1);
        check("5A_lsb", dl, 8'h5A);
        step(1'b0, 1'b0, 1'b0, 1'b1);

`ifdef RX_PARITY_CHECK_EN
        send_word(8'h4D, 1'b1, 1'b0);
        check("par_ok", pl, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send_word(8'h4D, 1'b1, 1'b1);
        check("par_bad", pl, 1'b1);
        check("par_data", dl, 8'h4D);
        step(1'b0, 1'b0, 1'b0, 1'b1);
`endif

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0,
                 1'($urandom),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 299) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
